tdpram32_port_arb: RTL and testbench

Arbiter and burst sequencer for the 32-bit port of the 64/32 dual-port RAM. It shares that port between two requesters, M0 (CPU data side) and M1 (DMA/debug). Arbitration is round-robin and each grant covers one burst of 1–16 words, for which the block generates incrementing word addresses. The 64-bit port is untouched and stays owned by its own master.

---
 rtl/tdpram32_port_arb.sv | 132 +++++++++++++
 tb/tb_tdpram32_port_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdpram32_port_arb.sv
// Round-robin arbiter and burst sequencer sharing the 32-bit RAM port
// between M0 (CPU data) and M1 (DMA/debug). Each grant is one burst of
// 1..16 beats with incrementing, wrapping word addresses.
module tdpram32_port_arb #(
   parameter int unsigned ADDR_WIDTH = 13
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH:0]   m0_addr,
   input  logic [3:0]            m0_blen,
   input  logic [3:0]            m0_byte_en,
   input  logic [31:0]           m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_ack,
   output logic                  m0_rvalid,
   output logic [31:0]           m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH:0]   m1_addr,
   input  logic [3:0]            m1_blen,
   input  logic [3:0]            m1_byte_en,
   input  logic [31:0]           m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_ack,
   output logic                  m1_rvalid,
   output logic [31:0]           m1_rdata,
   output logic                  we_32,
   output logic                  rd_32,
   output logic [3:0]            byte_en_32,
   output logic [ADDR_WIDTH:0]   addr_32,
   output logic [31:0]           wdata_32,
   input  logic [31:0]           rdata_32
);

   localparam int unsigned WA = ADDR_WIDTH + 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;    // 0 = M0, 1 = M1
   logic            we_q, we_d;
   logic [WA-1:0]   addr_q, addr_d;
   logic [3:0]      cnt_q, cnt_d;        // beats remaining after the current one
   logic            last_q, last_d;      // last winner, resets to M1
   logic            rvalid_q, rvalid_d;
   logic            rowner_q, rowner_d;
   logic            win;
   logic            burst;

   // State and burst context registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         cnt_q    <= 4'd0;
         last_q   <= 1'b1;
         rvalid_q <= 1'b0;
         rowner_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         rvalid_q <= rvalid_d;
         rowner_q <= rowner_d;
      end
   end

   // Arbitration in IDLE, beat sequencing in BURST
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      rvalid_d = 1'b0;
      rowner_d = rowner_q;
      win      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (m0_req || m1_req) begin
               win     = (m0_req && m1_req) ? ~last_q : m1_req;
               owner_d = win;
               last_d  = win;
               we_d    = win ? m1_we   : m0_we;
               addr_d  = win ? m1_addr : m0_addr;
               cnt_d   = win ? m1_blen : m0_blen;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            addr_d   = addr_q + WA'(1);
            cnt_d    = cnt_q - 4'd1;
            rvalid_d = ~we_q;
            rowner_d = owner_q;
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // RAM port and requester handshakes, decoded from registered state
   assign burst      = (state_q == ST_BURST);
   assign m0_gnt     = burst && !owner_q;
   assign m0_ack     = burst && !owner_q;
   assign m1_gnt     = burst && owner_q;
   assign m1_ack     = burst && owner_q;
   assign we_32      = burst && we_q;
   assign rd_32      = burst && !we_q;
   assign addr_32    = burst ? addr_q : '0;
   assign byte_en_32 = we_32 ? (owner_q ? m1_byte_en : m0_byte_en) : 4'h0;
   assign wdata_32   = we_32 ? (owner_q ? m1_wdata : m0_wdata) : 32'h0;

   // Read return steered to the owner of the captured read beat
   assign m0_rvalid  = rvalid_q && !rowner_q;
   assign m1_rvalid  = rvalid_q && rowner_q;
   assign m0_rdata   = m0_rvalid ? rdata_32 : 32'h0;
   assign m1_rdata   = m1_rvalid ? rdata_32 : 32'h0;

endmodule

// File: tb/tb_tdpram32_port_arb.sv
// Scoreboard bench for tdpram32_port_arb with a behavioural RAM model.
`timescale 1ns/1ps
module tb_tdpram32_port_arb;

   localparam int unsigned AW = 13;
   localparam int unsigned WA = AW + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m0_req = 1'b0, m0_we = 1'b0;
   logic [WA-1:0] m0_addr = '0;
   logic [3:0]    m0_blen = '0, m0_byte_en = '0;
   logic [31:0]   m0_wdata = '0;
   logic          m0_gnt, m0_ack, m0_rvalid;
   logic [31:0]   m0_rdata;
   logic          m1_req = 1'b0, m1_we = 1'b0;
   logic [WA-1:0] m1_addr = '0;
   logic [3:0]    m1_blen = '0, m1_byte_en = '0;
   logic [31:0]   m1_wdata = '0;
   logic          m1_gnt, m1_ack, m1_rvalid;
   logic [31:0]   m1_rdata;
   logic          we_32, rd_32;
   logic [3:0]    byte_en_32;
   logic [WA-1:0] addr_32;
   logic [31:0]   wdata_32;
   logic [31:0]   rdata_32;

   typedef struct {
      int            m;
      bit            we;
      logic [WA-1:0] addr;
      logic [3:0]    be;
      logic [31:0]   wd;
      bit            last;
   } beat_t;

   typedef struct {
      int          m;
      logic [31:0] data;
   } rd_t;

   beat_t       beat_q[$];
   rd_t         rd_q[$];
   int          applied = 0;
   int          miscompares = 0;
   logic [31:0] mem [0:(1<<WA)-1];
   logic [31:0] wd_tab [2][16];
   logic [3:0]  be_tab [2][16];

   always #5 clk = ~clk;

   tdpram32_port_arb #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_blen(m0_blen),
      .m0_byte_en(m0_byte_en), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_blen(m1_blen),
      .m1_byte_en(m1_byte_en), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .we_32(we_32), .rd_32(rd_32), .byte_en_32(byte_en_32), .addr_32(addr_32),
      .wdata_32(wdata_32), .rdata_32(rdata_32)
   );

   // RAM model: byte-enabled write, registered read
   initial begin
      for (int i = 0; i < (1 << WA); i++) mem[i] = 32'h0;
      mem[14'h0010] = 32'hA0; mem[14'h0011] = 32'hA1;
      mem[14'h0012] = 32'hA2; mem[14'h0013] = 32'hA3;
      mem[14'h0022] = 32'hDEADBEEF;
      mem[14'h3FFE] = 32'hC0; mem[14'h3FFF] = 32'hC1;
      mem[14'h0000] = 32'hC2; mem[14'h0001] = 32'hC3;
      mem[14'h0100] = 32'hB0; mem[14'h0101] = 32'hB1; mem[14'h0102] = 32'hB2;
      mem[14'h0200] = 32'hD0; mem[14'h0201] = 32'hD1;
      mem[14'h0300] = 32'hE0; mem[14'h0301] = 32'hE1;
      rdata_32 = 32'h0;
      forever begin
         @(posedge clk);
         if (we_32) begin
            for (int b = 0; b < 4; b++)
               if (byte_en_32[b]) mem[addr_32][8*b +: 8] = wdata_32[8*b +: 8];
         end
         if (rd_32) rdata_32 <= mem[addr_32];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_burst(input int m, input bit we, input logic [WA-1:0] addr,
                             input int blen);
      beat_t b;
      for (int i = 0; i <= blen; i++) begin
         b.m    = m;
         b.we   = we;
         b.addr = WA'(addr + WA'(i));
         b.be   = be_tab[m][i];
         b.wd   = wd_tab[m][i];
         b.last = (i == blen);
         beat_q.push_back(b);
      end
   endtask

   task automatic push_read(input int m, input logic [31:0] data);
      rd_t r;
      r.m    = m;
      r.data = data;
      rd_q.push_back(r);
   endtask

   task automatic set_master(input int m, input logic req, input logic we,
                             input logic [WA-1:0] addr, input logic [3:0] blen,
                             input logic [3:0] be, input logic [31:0] wd);
      if (m == 0) begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_blen = blen;
         m0_byte_en = be; m0_wdata = wd;
      end else begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_blen = blen;
         m1_byte_en = be; m1_wdata = wd;
      end
   endtask

   // Requester driver: holds req until the last ack, advances write data per ack
   task automatic run_burst(input int m, input bit we, input logic [WA-1:0] addr,
                            input int blen, input bit drop_early);
      int  done = 0;
      int  cyc = 0;
      bit  req = 1'b1;
      set_master(m, 1'b1, we, addr, 4'(blen), be_tab[m][0], wd_tab[m][0]);
      while (done < blen + 1 && cyc < 64) begin
         @(negedge clk);
         cyc++;
         if ((m == 0) ? m0_ack : m1_ack) done++;
         @(posedge clk);
         #1;
         if (done == blen + 1 || (drop_early && done >= 1)) req = 1'b0;
         set_master(m, req, we, addr, 4'(blen),
                    be_tab[m][done % 16], wd_tab[m][done % 16]);
      end
      set_master(m, 1'b0, 1'b0, '0, 4'd0, 4'h0, 32'h0);
      check($sformatf("burst_done_m%0d", m), 32'(done), 32'(blen + 1));
   endtask

   // Monitor: pops expectations whenever the DUT shows a beat or read data
   task automatic monitor();
      bit    prev_last = 1'b0;
      bit    prev_rd = 1'b0;
      bit    ack_any, rv_any;
      beat_t b;
      rd_t   r;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_outputs_zero",
                  32'(|{m0_gnt, m0_ack, m0_rvalid, m0_rdata, m1_gnt, m1_ack, m1_rvalid,
                        m1_rdata, we_32, rd_32, byte_en_32, addr_32, wdata_32}), 32'h0);
            prev_last = 1'b0;
            prev_rd   = 1'b0;
         end else begin
            ack_any = m0_ack | m1_ack;
            if (prev_last) check("bubble_after_burst", 32'({m1_gnt, m0_gnt}), 32'h0);
            prev_last = 1'b0;
            if (ack_any) begin
               check("beat_expected", 32'(beat_q.size() != 0), 32'h1);
               if (beat_q.size() != 0) begin
                  b = beat_q.pop_front();
                  check("beat_owner", 32'({m1_gnt, m0_gnt, m1_ack, m0_ack}),
                        (b.m != 0) ? 32'hA : 32'h5);
                  check("beat_we_rd", 32'({we_32, rd_32}), b.we ? 32'h2 : 32'h1);
                  check("beat_addr", 32'(addr_32), 32'(b.addr));
                  check("beat_byte_en", 32'(byte_en_32), b.we ? 32'(b.be) : 32'h0);
                  check("beat_wdata", wdata_32, b.we ? b.wd : 32'h0);
                  prev_last = b.last;
               end
            end
            rv_any = m0_rvalid | m1_rvalid;
            if (rv_any || prev_rd) check("rvalid_timing", 32'(rv_any), 32'(prev_rd));
            if (rv_any) begin
               check("rd_expected", 32'(rd_q.size() != 0), 32'h1);
               if (rd_q.size() != 0) begin
                  r = rd_q.pop_front();
                  check("rd_owner", 32'({m1_rvalid, m0_rvalid}), (r.m != 0) ? 32'h2 : 32'h1);
                  check("rd_data", (r.m != 0) ? m1_rdata : m0_rdata, r.data);
                  check("rd_other_zero", (r.m != 0) ? m0_rdata : m1_rdata, 32'h0);
               end
            end
            prev_rd = rd_32;
         end
      end
   endtask

   initial begin
      int acks;
      int cyc;
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 16; i++) begin
            wd_tab[m][i] = 32'h0;
            be_tab[m][i] = 4'h0;
         end
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Single read burst
      push_burst(0, 1'b0, 14'h0010, 3);
      push_read(0, 32'hA0); push_read(0, 32'hA1);
      push_read(0, 32'hA2); push_read(0, 32'hA3);
      run_burst(0, 1'b0, 14'h0010, 3, 1'b0);

      // Write with partial byte enables, then read back
      wd_tab[1][0] = 32'h11223344; be_tab[1][0] = 4'hF;
      wd_tab[1][1] = 32'h55667788; be_tab[1][1] = 4'h3;
      push_burst(1, 1'b1, 14'h0021, 1);
      run_burst(1, 1'b1, 14'h0021, 1, 1'b0);
      push_burst(0, 1'b0, 14'h0021, 1);
      push_read(0, 32'h11223344); push_read(0, 32'hDEAD7788);
      run_burst(0, 1'b0, 14'h0021, 1, 1'b0);

      // Address wrap
      push_burst(0, 1'b0, 14'h3FFE, 3);
      push_read(0, 32'hC0); push_read(0, 32'hC1);
      push_read(0, 32'hC2); push_read(0, 32'hC3);
      run_burst(0, 1'b0, 14'h3FFE, 3, 1'b0);

      // Req dropped after first ack: full burst still issued
      wd_tab[1][0] = 32'hAAAA0001; be_tab[1][0] = 4'hF;
      wd_tab[1][1] = 32'hAAAA0002; be_tab[1][1] = 4'hF;
      wd_tab[1][2] = 32'hAAAA0003; be_tab[1][2] = 4'hF;
      push_burst(1, 1'b1, 14'h0040, 2);
      run_burst(1, 1'b1, 14'h0040, 2, 1'b1);
      push_burst(0, 1'b0, 14'h0040, 2);
      push_read(0, 32'hAAAA0001); push_read(0, 32'hAAAA0002); push_read(0, 32'hAAAA0003);
      run_burst(0, 1'b0, 14'h0040, 2, 1'b0);

      // Reset during the 3rd beat of a 16-beat read
      push_burst(0, 1'b0, 14'h0100, 1);
      beat_q[beat_q.size()-1].last = 1'b0;
      push_read(0, 32'hB0);
      set_master(0, 1'b1, 1'b0, 14'h0100, 4'hF, 4'h0, 32'h0);
      acks = 0;
      cyc  = 0;
      while (acks < 2 && cyc < 32) begin
         @(negedge clk);
         cyc++;
         if (m0_ack) acks++;
      end
      check("rst_test_acks", 32'(acks), 32'd2);
      @(posedge clk);
      #1 rst = 1'b1;
      set_master(0, 1'b0, 1'b0, '0, 4'd0, 4'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Contention: M0 first after reset, then strict alternation
      for (int m = 0; m < 2; m++) begin
         wd_tab[m][0] = 32'h0;
         be_tab[m][0] = 4'h0;
      end
      push_burst(0, 1'b0, 14'h0200, 0); push_read(0, 32'hD0);
      push_burst(1, 1'b0, 14'h0300, 0); push_read(1, 32'hE0);
      push_burst(0, 1'b0, 14'h0201, 0); push_read(0, 32'hD1);
      push_burst(1, 1'b0, 14'h0301, 0); push_read(1, 32'hE1);
      fork
         begin
            run_burst(0, 1'b0, 14'h0200, 0, 1'b0);
            run_burst(0, 1'b0, 14'h0201, 0, 1'b0);
         end
         begin
            run_burst(1, 1'b0, 14'h0300, 0, 1'b0);
            run_burst(1, 1'b0, 14'h0301, 0, 1'b0);
         end
      join

      repeat (5) @(posedge clk);
      #1;
      check("beat_queue_drained", 32'(beat_q.size()), 32'h0);
      check("rd_queue_drained", 32'(rd_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
